uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the UART receiver.
//   uart_rx_state_t : receive FSM states (idle, start-bit check, data, stop).
package uart_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_rx_state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchroniser for asynchronous inputs, reset to 1 (idle line).
// Ports:
//   clk   in          : destination clock
//   rst_n in          : asynchronous reset, active high
//   d     in  [WIDTH] : asynchronous input
//   q     out [WIDTH] : synchronised output
module uart_rx_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Deserialises frames from rx into bytes.
// Ports:
//   clk          in     : main clock (CLK_F Hz)
//   rst_n        in     : asynchronous reset, active high
//   rx           in     : serial input, asynchronous, idle high
//   rx_pdata     out[8] : last correctly framed byte, held until the next good frame
//   rx_pdvalid   out    : one-cycle pulse when rx_pdata is updated
//   rx_frame_err out    : one-cycle pulse when the stop bit is sampled low
//   rx_busy      out    : high while the FSM is not idle
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLK_F  = 50000000,
   parameter int unsigned UART_B = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_pdata,
   output logic       rx_pdvalid,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int unsigned BAUD_CNT_MAX = CLK_F / UART_B;
   localparam int unsigned BAUD_HALF    = BAUD_CNT_MAX / 2;
   localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
   localparam logic [15:0] HALF_LAST    = 16'(BAUD_HALF - 1);

   logic           rx_s;
   logic           rx_d;
   logic           fall;

   uart_rx_state_t state,    state_nxt;
   logic [15:0]    baud_cnt, baud_nxt;
   logic [2:0]     bit_cnt,  bit_nxt;
   logic [7:0]     shift,    shift_nxt;
   logic [7:0]     pdata_nxt;
   logic           valid_nxt;
   logic           ferr_nxt;

   uart_rx_sync #(.WIDTH(1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) rx_d <= 1'b1;
      else       rx_d <= rx_s;
   end

   assign fall = rx_d & ~rx_s;

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      pdata_nxt = rx_pdata;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fall) begin
               state_nxt = ST_START;
               baud_nxt  = '0;
            end
         end
         ST_START: begin
            // Re-check the start bit at its mid-point; a high line here is a glitch.
            if (baud_cnt == HALF_LAST) begin
               baud_nxt = '0;
               if (!rx_s) begin
                  state_nxt = ST_DATA;
                  bit_nxt   = '0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               baud_nxt = baud_cnt + 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_nxt  = '0;
               shift_nxt = {rx_s, shift[7:1]};
               bit_nxt   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = ST_STOP;
            end else begin
               baud_nxt = baud_cnt + 16'd1;
            end
         end
         ST_STOP: begin
            // Leave at the stop-bit mid-point so a back-to-back start edge is caught.
            if (baud_cnt == BAUD_LAST) begin
               baud_nxt  = '0;
               state_nxt = ST_IDLE;
               if (rx_s) begin
                  pdata_nxt = shift;
                  valid_nxt = 1'b1;
               end else begin
                  ferr_nxt  = 1'b1;
               end
            end else begin
               baud_nxt = baud_cnt + 16'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state        <= ST_IDLE;
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         rx_pdata     <= '0;
         rx_pdvalid   <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_busy      <= 1'b0;
      end else begin
         state        <= state_nxt;
         baud_cnt     <= baud_nxt;
         bit_cnt      <= bit_nxt;
         shift        <= shift_nxt;
         rx_pdata     <= pdata_nxt;
         rx_pdvalid   <= valid_nxt;
         rx_frame_err <= ferr_nxt;
         // Decoded from the next state so busy tracks the state register exactly.
         rx_busy      <= (state_nxt != ST_IDLE);
      end
   end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned CLK_F  = 1000000;
   localparam int unsigned UART_B = 100000;
   localparam int unsigned CLK_NS = 1000;
   localparam int unsigned BIT_NS = 10000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] rx_pdata;
   logic       rx_pdvalid;
   logic       rx_frame_err;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_ferr = 0;
   int ferr_seen = 0;
   logic [7:0] exp_q[$];
   int pulse_cyc[$];

   uart_rx #(.CLK_F(CLK_F), .UART_B(UART_B)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .rx_pdata     (rx_pdata),
      .rx_pdvalid   (rx_pdvalid),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy)
   );

   always #(CLK_NS/2) clk = ~clk;

   // Scoreboard monitor: pops expected bytes / frame errors as the DUT reports them.
   always @(negedge clk) begin
      logic [7:0] e;
      cyc++;
      if (rx_pdvalid || rx_frame_err) begin
         checks++;
         if (rx_pdvalid && rx_frame_err) begin
            errors++;
            $display("FAIL excl: valid=%0b frame_err=%0b, required not both", rx_pdvalid, rx_frame_err);
         end
      end
      if (rx_pdvalid) begin
         checks++;
         pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got data 0x%02h, no byte expected", rx_pdata);
         end else begin
            e = exp_q.pop_front();
            if (rx_pdata !== e) begin
               errors++;
               $display("FAIL rx_pdata: got 0x%02h, expected 0x%02h", rx_pdata, e);
            end
         end
      end
      if (rx_frame_err) begin
         checks++;
         ferr_seen++;
         if (exp_ferr == 0) begin
            errors++;
            $display("FAIL unexpected_frame_err: got 1, expected 0");
         end else begin
            exp_ferr--;
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input int unsigned per_ns, input logic stop);
      rx = 1'b0;
      #(per_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(per_ns);
      end
      rx = stop;
      #(per_ns);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || exp_ferr != 0); i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || exp_ferr != 0) begin
         errors++;
         $display("FAIL %s_timeout: pending bytes=%0d frame_errs=%0d, expected 0/0", name, exp_q.size(), exp_ferr);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({rx_pdata, rx_pdvalid, rx_frame_err, rx_busy} !== 11'h000) begin
         errors++;
         $display("FAIL reset_outputs: got data=0x%02h v=%0b fe=%0b busy=%0b, expected all 0",
                  rx_pdata, rx_pdvalid, rx_frame_err, rx_busy);
      end
   endtask

   task automatic test_single();
      exp_q.push_back(8'hA5);
      @(negedge clk);
      fork
         send_frame(8'hA5, BIT_NS, 1'b1);
         begin
            repeat (20) @(negedge clk);
            checks++;
            if (rx_busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_mid_frame: got %0b, expected 1", rx_busy);
            end
         end
      join
      wait_drain("single");
      repeat (2) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_frame: got %0b, expected 0", rx_busy);
      end
   endtask

   task automatic test_back_to_back();
      pulse_cyc.delete();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h55);
      @(negedge clk);
      send_frame(8'h00, BIT_NS, 1'b1);
      send_frame(8'hFF, BIT_NS, 1'b1);
      send_frame(8'h55, BIT_NS, 1'b1);
      wait_drain("b2b");
      checks++;
      if (pulse_cyc.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses, expected 3", pulse_cyc.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 100) begin
               errors++;
               $display("FAIL b2b_spacing%0d: got %0d clk, expected 100", i, pulse_cyc[i] - pulse_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_glitch();
      int np;
      int nf;
      np = pulse_cyc.size();
      nf = ferr_seen;
      repeat (5) @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_start_entered: busy got %0b, expected 1", rx_busy);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b0 || pulse_cyc.size() != np || ferr_seen != nf) begin
         errors++;
         $display("FAIL glitch_reject: busy=%0b pulses+%0d ferr+%0d, expected 0/0/0",
                  rx_busy, pulse_cyc.size() - np, ferr_seen - nf);
      end
      exp_q.push_back(8'h3C);
      @(negedge clk);
      send_frame(8'h3C, BIT_NS, 1'b1);
      wait_drain("glitch_follow");
   endtask

   task automatic test_frame_err();
      int nf;
      do_reset();
      nf = ferr_seen;
      exp_ferr = 1;
      @(negedge clk);
      send_frame(8'h81, BIT_NS, 1'b0);
      #(50 * CLK_NS);
      checks++;
      if (rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL break_idle: busy got %0b, expected 0", rx_busy);
      end
      rx = 1'b1;
      repeat (20) @(negedge clk);
      wait_drain("frame_err");
      checks++;
      if (ferr_seen - nf != 1) begin
         errors++;
         $display("FAIL ferr_count: got %0d, expected 1", ferr_seen - nf);
      end
      checks++;
      if (rx_pdata !== 8'h00) begin
         errors++;
         $display("FAIL ferr_pdata_hold: got 0x%02h, expected 0x00", rx_pdata);
      end
      exp_q.push_back(8'h42);
      @(negedge clk);
      send_frame(8'h42, BIT_NS, 1'b1);
      wait_drain("after_break");
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      int np;
      b = 8'hF0;
      @(negedge clk);
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         #(BIT_NS);
      end
      rx = b[4];
      #(BIT_NS/2);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({rx_pdata, rx_pdvalid, rx_frame_err, rx_busy} !== 11'h000) begin
         errors++;
         $display("FAIL midreset_outputs: got data=0x%02h v=%0b fe=%0b busy=%0b, expected all 0",
                  rx_pdata, rx_pdvalid, rx_frame_err, rx_busy);
      end
      @(negedge clk);
      rst_n = 1'b0;
      rx    = 1'b1;
      np    = pulse_cyc.size();
      repeat (120) @(negedge clk);
      checks++;
      if (pulse_cyc.size() != np || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_silent: pulses+%0d busy=%0b, expected 0/0", pulse_cyc.size() - np, rx_busy);
      end
      exp_q.push_back(8'h17);
      @(negedge clk);
      send_frame(8'h17, BIT_NS, 1'b1);
      wait_drain("after_midreset");
   endtask

   task automatic test_baud_sweep();
      int unsigned pers[5];
      pers = '{9800, 9900, 10000, 10100, 10200};
      foreach (pers[k]) begin
         exp_q.push_back(8'h96);
         @(negedge clk);
         #(k * 137);
         send_frame(8'h96, pers[k], 1'b1);
         #(2 * BIT_NS);
         wait_drain("baud_sweep");
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid_frame();
      test_baud_sweep();
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || exp_ferr != 0) begin
         errors++;
         $display("FAIL final_scoreboard: pending bytes=%0d frame_errs=%0d, expected 0/0", exp_q.size(), exp_ferr);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(60000 * CLK_NS);
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule : tb_uart_rx
